// File: rtl/mem_bus_sequencer_pkg.sv
`default_nettype none
`ifndef W_DATA
`define W_DATA 32
`endif
// +--------------------------------------------------------------------------+
// | Module      : mem_bus_sequencer_pkg                                      |
// | Description : Shared types and constants for the memory bus sequencer:  |
// |               FSM state encoding, default NOP word, address helpers.    |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_bus_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECIDE = 3'd2,
      S_DATA   = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   // Instruction presented to decode after reset and after a fetch timeout.
   localparam logic [`W_DATA-1:0] C_NOP_WORD = '0;

   // The bus is word addressed: byte offset bits are forced to zero.
   function automatic logic [`W_DATA-1:0] word_align(input logic [`W_DATA-1:0] addr);
      return addr & ~(`W_DATA'(3));
   endfunction

   function automatic logic is_misaligned(input logic [1:0] byte_ofs);
      return byte_ofs != 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_sequencer_if.sv
`default_nettype none
`ifndef W_DATA
`define W_DATA 32
`endif
// +--------------------------------------------------------------------------+
// | Module      : mem_bus_sequencer_if                                       |
// | Description : Shared memory bus with a req/ack handshake.                |
// | Ports       : req/we/addr/wdata driven by the master,                   |
// |               rdata/ack driven by the slave (memory).                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mem_bus_sequencer_if;
   logic               req;
   logic               we;
   logic [`W_DATA-1:0] addr;
   logic [`W_DATA-1:0] wdata;
   logic [`W_DATA-1:0] rdata;
   logic               ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/mem_bus_sequencer_bus_timeout_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_bus_sequencer_bus_timeout_ctr                          |
// | Description : Wait counter for one bus transaction. Counts cycles in    |
// |               which a request is outstanding without ack and flags the  |
// |               cycle in which the TIMEOUT-th such cycle occurs.           |
// | Ports       : clk, rst   clock / async active-high reset                 |
// |               clear_i    force count to zero                             |
// |               en_i       request outstanding and not acknowledged        |
// |               expire_o   this cycle is the last allowed wait cycle       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_bus_sequencer_bus_timeout_ctr #(
   parameter int TIMEOUT = 255,   // must be >= 1 and < 2**W_TO
   parameter int W_TO    = 8
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clear_i,
   input  wire logic en_i,
   output logic      expire_o
);

   localparam logic [W_TO-1:0] C_LAST = W_TO'(TIMEOUT - 1);

   logic [W_TO-1:0] count_q;
   logic [W_TO-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + W_TO'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is gated by en_i so an ack in the final cycle takes priority.
   assign expire_o = en_i && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_bus_sequencer.sv
`default_nettype none
`ifndef W_DATA
`define W_DATA 32
`endif
// +--------------------------------------------------------------------------+
// | Module      : mem_bus_sequencer                                          |
// | Description : Multi-cycle sequencer between a single-cycle core and one |
// |               shared req/ack memory bus. Each instruction is a fetch    |
// |               followed by an optional load/store; the core is stalled   |
// |               except for exactly one commit cycle per instruction.      |
// | Ports       : clk, rst        clock / async active-high reset           |
// |               if_addr_i       program counter (fetch address)           |
// |               ir_o            latched instruction word                  |
// |               dm_req_i        decoded load/store pending                 |
// |               dm_we_i         1 = store, 0 = load                         |
// |               dm_addr_i       data address                               |
// |               dm_wdata_i      store data                                 |
// |               dm_rdata_o      latched load data                          |
// |               stall_o         PC and architectural writes held           |
// |               bus             memory bus (master side)                   |
// |               bus_err_o       sticky timeout / misalignment flag         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_bus_sequencer
   import mem_bus_sequencer_pkg::*;
#(
   parameter int                 TIMEOUT  = 255,
   parameter int                 W_TO     = 8,
   parameter logic [`W_DATA-1:0] NOP_WORD = C_NOP_WORD
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic [`W_DATA-1:0] if_addr_i,
   output logic      [`W_DATA-1:0] ir_o,
   input  wire logic               dm_req_i,
   input  wire logic               dm_we_i,
   input  wire logic [`W_DATA-1:0] dm_addr_i,
   input  wire logic [`W_DATA-1:0] dm_wdata_i,
   output logic      [`W_DATA-1:0] dm_rdata_o,
   output logic                    stall_o,
   mem_bus_sequencer_if.master     bus,
   output logic                    bus_err_o
);

   state_t             state_q, state_d;
   logic [`W_DATA-1:0] ir_q, ir_d;
   logic [`W_DATA-1:0] dm_rdata_q, dm_rdata_d;
   logic               bus_err_q, bus_err_d;

   logic               w_bus_active;
   logic               w_to_en;
   logic               w_to_expire;

   // The request is a pure function of state, so reset drops it
   // asynchronously together with the state register.
   assign w_bus_active = (state_q == S_FETCH) || (state_q == S_DATA);
   assign bus.req      = w_bus_active;
   assign w_to_en      = w_bus_active && !bus.ack;

   // Counter is held clear whenever no request is outstanding, which makes
   // it zero on every entry to FETCH or DATA.
   mem_bus_sequencer_bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .W_TO    (W_TO)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (!w_bus_active),
      .en_i     (w_to_en),
      .expire_o (w_to_expire)
   );

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      dm_rdata_d = dm_rdata_q;
      bus_err_d  = bus_err_q;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.wdata  = '0;
      stall_o    = 1'b1;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            bus.addr = word_align(if_addr_i);
            if (bus.ack) begin
               ir_d    = bus.rdata;
               state_d = S_DECIDE;
            end else if (w_to_expire) begin
               ir_d      = NOP_WORD;
               bus_err_d = 1'b1;
               state_d   = S_COMMIT;
            end
         end

         // One idle bus cycle so decode can see the new ir before dm_req
         // is sampled.
         S_DECIDE: begin
            if (dm_req_i) begin
               if (is_misaligned(dm_addr_i[1:0])) begin
                  bus_err_d = 1'b1;
                  state_d   = S_COMMIT;
               end else begin
                  state_d   = S_DATA;
               end
            end else begin
               state_d = S_COMMIT;
            end
         end

         S_DATA: begin
            bus.we    = dm_we_i;
            bus.addr  = word_align(dm_addr_i);
            bus.wdata = dm_wdata_i;
            if (bus.ack) begin
               if (!dm_we_i) begin
                  dm_rdata_d = bus.rdata;
               end
               state_d = S_COMMIT;
            end else if (w_to_expire) begin
               bus_err_d = 1'b1;
               state_d   = S_COMMIT;
            end
         end

         S_COMMIT: begin
            stall_o = 1'b0;
            state_d = S_FETCH;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ir_q       <= NOP_WORD;
         dm_rdata_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         dm_rdata_q <= dm_rdata_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign ir_o       = ir_q;
   assign dm_rdata_o = dm_rdata_q;
   assign bus_err_o  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_sequencer.sv
`default_nettype none
module tb_mem_bus_sequencer;

   localparam int          TMO = 4;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] ir;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        stall;
   logic        bus_err;

   mem_bus_sequencer_if bus ();

   mem_bus_sequencer #(
      .TIMEOUT  (TMO),
      .W_TO     (8),
      .NOP_WORD (NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_addr_i  (if_addr),
      .ir_o       (ir),
      .dm_req_i   (dm_req),
      .dm_we_i    (dm_we),
      .dm_addr_i  (dm_addr),
      .dm_wdata_i (dm_wdata),
      .dm_rdata_o (dm_rdata),
      .stall_o    (stall),
      .bus        (bus),
      .bus_err_o  (bus_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Observations of one instruction, filled by run_instr.
   int          ob_commit, ob_f_cycles, ob_d_cycles, ob_bursts;
   bit          ob_hung, ob_first_req, ob_stable, ob_f_clean;
   logic [31:0] ob_f_addr, ob_d_addr, ob_d_wdata, ob_ir, ob_rdata, ob_ir_after_fetch;
   logic        ob_d_we, ob_err;

   // Reference model: expected timeline and architectural state.
   int          ex_commit, ex_f_cycles, ex_d_cycles;
   logic [31:0] ex_ir = NOP, ex_rdata = '0, ex_f_addr, ex_d_addr;
   logic        ex_err = 1'b0;

   // Memory-side behaviour: fwait/dwait = wait cycles before ack (>= TMO
   // means never acknowledged). Starts in the first FETCH cycle.
   task automatic run_instr(input logic [31:0] pc, instr, input logic dreq, dwe,
                            input logic [31:0] daddr, dwdata, drdata,
                            input int fwait, dwait, input bit stray);
      int  cnt;
      bit  prev_req;
      bit  af_done;
      cnt = 0; prev_req = 0; af_done = 0;
      ob_hung = 1; ob_bursts = 0; ob_f_cycles = 0; ob_d_cycles = 0;
      ob_stable = 1; ob_f_clean = 1; ob_first_req = 0; ob_commit = -1;
      ob_ir_after_fetch = 'x;
      if_addr = pc; dm_req = dreq; dm_we = dwe; dm_addr = daddr; dm_wdata = dwdata;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (c == 0) ob_first_req = bus.req;
         if (!stall) begin
            ob_commit = c; ob_ir = ir; ob_rdata = dm_rdata; ob_err = bus_err; ob_hung = 0;
            bus.ack = 1'b0;
            @(posedge clk); #1;
            break;
         end
         if (bus.req) begin
            if (!prev_req) begin ob_bursts++; cnt = 0; end
            if (ob_bursts == 1) begin
               if (cnt == 0) ob_f_addr = bus.addr;
               else if (bus.addr !== ob_f_addr) ob_stable = 0;
               if (bus.we !== 1'b0 || bus.wdata !== 32'h0) ob_f_clean = 0;
               ob_f_cycles++;
               bus.ack = (cnt == fwait); bus.rdata = instr;
            end else begin
               if (cnt == 0) begin ob_d_addr = bus.addr; ob_d_we = bus.we; ob_d_wdata = bus.wdata; end
               else if (bus.addr !== ob_d_addr || bus.we !== ob_d_we || bus.wdata !== ob_d_wdata) ob_stable = 0;
               ob_d_cycles++;
               bus.ack = (cnt == dwait); bus.rdata = drdata;
            end
            cnt++;
         end else begin
            if (ob_bursts == 1 && !af_done) begin ob_ir_after_fetch = ir; af_done = 1; end
            bus.ack = stray; bus.rdata = $urandom();
         end
         prev_req = bus.req;
         @(posedge clk);
      end
   endtask

   // Expected outcome derived from the sequencing rules.
   task automatic predict(input logic [31:0] pc, instr, input logic dreq, dwe,
                          input logic [31:0] daddr, drdata, input int fwait, dwait);
      ex_f_addr   = (pc / 4) * 4;
      ex_d_addr   = (daddr / 4) * 4;
      ex_d_cycles = 0;
      if (fwait >= TMO) begin
         ex_f_cycles = TMO; ex_ir = NOP; ex_err = 1; ex_commit = TMO;
      end else begin
         ex_f_cycles = fwait + 1; ex_ir = instr; ex_commit = ex_f_cycles + 1;
         if (dreq) begin
            if (daddr % 4 != 0) begin
               ex_err = 1;
            end else begin
               ex_d_cycles = (dwait >= TMO) ? TMO : dwait + 1;
               ex_commit  += ex_d_cycles;
               if (dwait >= TMO) ex_err = 1;
               else if (!dwe) ex_rdata = drdata;
            end
         end
      end
   endtask

   task automatic do_reset(input logic [31:0] pc);
      if_addr = pc; bus.ack = 1'b0; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      ex_ir = NOP; ex_rdata = '0; ex_err = 1'b0;
   endtask

   task automatic test_reset();
      bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF; if_addr = 32'h0000_0103;
      #2 rst = 1'b1; #1;
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall: got %b expected 1", stall); end
      n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", bus.req); end
      n_checks++; if (ir !== NOP) begin n_errors++; $display("FAIL reset_ir: got %h expected %h", ir, NOP); end
      n_checks++; if (dm_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", dm_rdata); end
      n_checks++; if (bus_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", bus_err); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; #1;
      n_checks++; if (bus.req !== 1'b0 || stall !== 1'b1) begin n_errors++; $display("FAIL idle_cycle: req=%b stall=%b expected req=0 stall=1", bus.req, stall); end
      @(posedge clk); #1;
      bus.ack = 1'b0;
      n_checks++; if (bus.req !== 1'b1) begin n_errors++; $display("FAIL fetch_after_idle: req=%b expected 1", bus.req); end
      n_checks++; if (bus.addr !== 32'h0000_0100) begin n_errors++; $display("FAIL fetch_addr_align: got %h expected 00000100", bus.addr); end
      ex_ir = NOP; ex_rdata = '0; ex_err = 1'b0;
   endtask

   task automatic test_alu_zero_wait();
      predict(32'h103, 32'h2408_0005, 0, 0, 0, 0, 0, 0);
      run_instr(32'h103, 32'h2408_0005, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (ob_commit !== 2) begin n_errors++; $display("FAIL alu_commit_idx: got %0d expected 2", ob_commit); end
      n_checks++; if (ob_ir_after_fetch !== 32'h2408_0005) begin n_errors++; $display("FAIL alu_ir_decide: got %h expected 24080005", ob_ir_after_fetch); end
      n_checks++; if (ob_ir !== ex_ir) begin n_errors++; $display("FAIL alu_ir: got %h expected %h", ob_ir, ex_ir); end
      n_checks++; if (ob_bursts !== 1 || ob_f_cycles !== 1) begin n_errors++; $display("FAIL alu_req_pattern: bursts=%0d fcyc=%0d expected 1/1", ob_bursts, ob_f_cycles); end
      n_checks++; if (ob_f_addr !== 32'h100 || !ob_f_clean) begin n_errors++; $display("FAIL alu_fetch_bus: addr=%h clean=%0d expected 00000100/1", ob_f_addr, ob_f_clean); end
      predict(32'h104, 32'h0128_5020, 0, 0, 0, 0, 0, 0);
      run_instr(32'h104, 32'h0128_5020, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (ob_first_req !== 1'b1) begin n_errors++; $display("FAIL alu_commit_one_cycle: next req=%b expected 1", ob_first_req); end
      n_checks++; if (ob_commit !== ex_commit || ob_ir !== ex_ir) begin n_errors++; $display("FAIL alu_second: idx=%0d ir=%h expected %0d/%h", ob_commit, ob_ir, ex_commit, ex_ir); end
   endtask

   task automatic test_store_waits();
      predict(32'h108, 32'hAC0A_0010, 1, 1, 32'h1000_0010, 0, 0, 2);
      run_instr(32'h108, 32'hAC0A_0010, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 0, 2, 0);
      n_checks++; if (ob_d_cycles !== 3) begin n_errors++; $display("FAIL store_req_cycles: got %0d expected 3", ob_d_cycles); end
      n_checks++; if (ob_d_we !== 1'b1 || ob_d_addr !== 32'h1000_0010 || ob_d_wdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL store_bus: we=%b addr=%h wdata=%h expected 1/10000010/deadbeef", ob_d_we, ob_d_addr, ob_d_wdata); end
      n_checks++; if (!ob_stable) begin n_errors++; $display("FAIL store_stable: got 0 expected 1"); end
      n_checks++; if (ob_commit !== 5) begin n_errors++; $display("FAIL store_commit_idx: got %0d expected 5", ob_commit); end
      n_checks++; if (ob_rdata !== ex_rdata) begin n_errors++; $display("FAIL store_rdata_kept: got %h expected %h", ob_rdata, ex_rdata); end
   endtask

   task automatic test_load_stray();
      predict(32'h10C, 32'h8C09_0014, 1, 0, 32'h1000_0014, 32'hA5, 1, 1);
      run_instr(32'h10C, 32'h8C09_0014, 1, 0, 32'h1000_0014, 0, 32'h0000_00A5, 1, 1, 1);
      n_checks++; if (ob_rdata !== 32'hA5) begin n_errors++; $display("FAIL load_rdata: got %h expected 000000a5", ob_rdata); end
      n_checks++; if (ob_f_cycles !== 2 || ob_d_cycles !== 2) begin n_errors++; $display("FAIL load_stray_cycles: f=%0d d=%0d expected 2/2", ob_f_cycles, ob_d_cycles); end
      n_checks++; if (ob_commit !== ex_commit || ob_err !== 1'b0) begin n_errors++; $display("FAIL load_commit: idx=%0d err=%b expected %0d/0", ob_commit, ob_err, ex_commit); end
   endtask

   task automatic test_fetch_timeout();
      predict(32'h110, 32'h1234_5678, 0, 0, 0, 0, 10, 0);
      run_instr(32'h110, 32'h1234_5678, 0, 0, 0, 0, 0, 10, 0, 0);
      n_checks++; if (ob_f_cycles !== TMO || ob_bursts !== 1) begin n_errors++; $display("FAIL fto_req_cycles: got %0d/%0d expected %0d/1", ob_f_cycles, ob_bursts, TMO); end
      n_checks++; if (ob_commit !== TMO) begin n_errors++; $display("FAIL fto_commit_idx: got %0d expected %0d", ob_commit, TMO); end
      n_checks++; if (ob_ir !== NOP) begin n_errors++; $display("FAIL fto_ir_nop: got %h expected %h", ob_ir, NOP); end
      n_checks++; if (ob_err !== 1'b1) begin n_errors++; $display("FAIL fto_err: got %b expected 1", ob_err); end
      predict(32'h114, 32'h2402_0001, 0, 0, 0, 0, 0, 0);
      run_instr(32'h114, 32'h2402_0001, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (ob_err !== 1'b1 || ob_ir !== 32'h2402_0001) begin n_errors++; $display("FAIL fto_err_sticky: err=%b ir=%h expected 1/24020001", ob_err, ob_ir); end
   endtask

   task automatic test_misaligned();
      do_reset(32'h200);
      predict(32'h200, 32'h8C0B_0002, 1, 0, 32'h1000_0002, 32'h77, 0, 0);
      run_instr(32'h200, 32'h8C0B_0002, 1, 0, 32'h1000_0002, 0, 32'h77, 0, 0, 0);
      n_checks++; if (ob_bursts !== 1 || ob_d_cycles !== 0) begin n_errors++; $display("FAIL mis_no_data_req: bursts=%0d d=%0d expected 1/0", ob_bursts, ob_d_cycles); end
      n_checks++; if (ob_err !== 1'b1) begin n_errors++; $display("FAIL mis_err: got %b expected 1", ob_err); end
      n_checks++; if (ob_commit !== 2) begin n_errors++; $display("FAIL mis_commit_idx: got %0d expected 2", ob_commit); end
      n_checks++; if (ob_rdata !== ex_rdata) begin n_errors++; $display("FAIL mis_rdata: got %h expected %h", ob_rdata, ex_rdata); end
   endtask

   task automatic test_reset_mid_data();
      if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h1000_0020; dm_wdata = 0;
      bus.rdata = 32'h8C09_0020; bus.ack = 1;
      @(posedge clk); #1; bus.ack = 0;
      @(posedge clk); #1;
      n_checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h1000_0020) begin n_errors++; $display("FAIL rmd_in_data: req=%b addr=%h expected 1/10000020", bus.req, bus.addr); end
      @(posedge clk); #1;
      bus.ack = 1; bus.rdata = 32'h5555_5555; rst = 1; #1;
      n_checks++; if (bus.req !== 1'b0 || stall !== 1'b1) begin n_errors++; $display("FAIL rmd_async: req=%b stall=%b expected 0/1", bus.req, stall); end
      n_checks++; if (ir !== NOP || bus_err !== 1'b0 || dm_rdata !== 32'h0) begin n_errors++; $display("FAIL rmd_regs: ir=%h err=%b rdata=%h expected %h/0/0", ir, bus_err, dm_rdata, NOP); end
      @(posedge clk); #1; rst = 0; #1;
      n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL rmd_idle: req=%b expected 0", bus.req); end
      @(posedge clk); #1; bus.ack = 0;
      n_checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h40 || dm_rdata !== 32'h0) begin n_errors++; $display("FAIL rmd_refetch: req=%b addr=%h rdata=%h expected 1/00000040/0", bus.req, bus.addr, dm_rdata); end
      ex_ir = NOP; ex_rdata = '0; ex_err = 1'b0;
   endtask

   task automatic test_ack_at_timeout();
      predict(32'h40, 32'h8C0C_0030, 1, 0, 32'h1000_0030, 32'h1357_9BDF, TMO - 1, TMO - 1);
      run_instr(32'h40, 32'h8C0C_0030, 1, 0, 32'h1000_0030, 0, 32'h1357_9BDF, TMO - 1, TMO - 1, 0);
      n_checks++; if (ob_commit !== ex_commit) begin n_errors++; $display("FAIL ack_wins_idx: got %0d expected %0d", ob_commit, ex_commit); end
      n_checks++; if (ob_err !== 1'b0 || ob_ir !== ex_ir || ob_rdata !== ex_rdata) begin n_errors++; $display("FAIL ack_wins_state: err=%b ir=%h rdata=%h expected 0/%h/%h", ob_err, ob_ir, ob_rdata, ex_ir, ex_rdata); end
   endtask

   task automatic test_random();
      logic [31:0] pc, instr, daddr, dwdata, drdata;
      logic        dreq, dwe;
      int          fwait, dwait;
      bit          stray;
      pc = 32'h0000_0300;
      for (int i = 0; i < 40; i++) begin
         pc     = pc + 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         instr  = $urandom(); dwdata = $urandom(); drdata = $urandom();
         dreq   = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
         daddr  = $urandom();
         if ($urandom_range(0, 5) != 0) daddr[1:0] = 2'b00;
         fwait  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TMO - 1) : $urandom_range(TMO, TMO + 2);
         dwait  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TMO - 1) : $urandom_range(TMO, TMO + 2);
         stray  = 1'($urandom_range(0, 1));
         predict(pc, instr, dreq, dwe, daddr, drdata, fwait, dwait);
         run_instr(pc, instr, dreq, dwe, daddr, dwdata, drdata, fwait, dwait, stray);
         n_checks++; if (ob_hung || ob_commit !== ex_commit) begin n_errors++; $display("FAIL rnd%0d_commit_idx: got %0d expected %0d", i, ob_commit, ex_commit); end
         n_checks++; if (ob_ir !== ex_ir) begin n_errors++; $display("FAIL rnd%0d_ir: got %h expected %h", i, ob_ir, ex_ir); end
         n_checks++; if (ob_rdata !== ex_rdata) begin n_errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, ob_rdata, ex_rdata); end
         n_checks++; if (ob_err !== ex_err) begin n_errors++; $display("FAIL rnd%0d_err: got %b expected %b", i, ob_err, ex_err); end
         n_checks++; if (ob_f_cycles !== ex_f_cycles || ob_d_cycles !== ex_d_cycles) begin n_errors++; $display("FAIL rnd%0d_req_cycles: f=%0d d=%0d expected %0d/%0d", i, ob_f_cycles, ob_d_cycles, ex_f_cycles, ex_d_cycles); end
         n_checks++; if (ob_f_addr !== ex_f_addr || !ob_f_clean || !ob_stable || !ob_first_req) begin n_errors++; $display("FAIL rnd%0d_fetch_bus: addr=%h clean=%0d stable=%0d first=%0d expected %h/1/1/1", i, ob_f_addr, ob_f_clean, ob_stable, ob_first_req, ex_f_addr); end
         if (ex_d_cycles > 0) begin
            n_checks++; if (ob_d_addr !== ex_d_addr || ob_d_we !== dwe || ob_d_wdata !== dwdata) begin n_errors++; $display("FAIL rnd%0d_data_bus: addr=%h we=%b wdata=%h expected %h/%b/%h", i, ob_d_addr, ob_d_we, ob_d_wdata, ex_d_addr, dwe, dwdata); end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.ack = 1'b0;
      bus.rdata = '0;
      test_reset();
      test_alu_zero_wait();
      test_store_waits();
      test_load_stray();
      test_fetch_timeout();
      test_misaligned();
      test_reset_mid_data();
      test_ack_at_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_sequencer.md
Name: mem_bus_sequencer

Overview:
- Multi-cycle sequencer between the PLP core and a single shared memory bus with req/ack handshake.
- Each instruction runs as: fetch at the program-counter address, then an optional data load/store.
- Holds the program counter (stall) and register-file writes until the bus transactions complete.
- Opens exactly one commit cycle per instruction, so the single-cycle datapath keeps working over slow, shared memory.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for bus_ack before aborting a transaction.
- W_TO, 8: width of the timeout counter; TIMEOUT must be < 2**W_TO.
- NOP_WORD, 32'h0000_0000: instruction substituted when a fetch times out.

Ports:
- clk  in  1  system clock (rising edge)
- rst  in  1  asynchronous reset, active-high
- if_addr  in  `W_DATA  fetch address from program counter (imem_addr)
- ir  out  `W_DATA  latched instruction word presented to decode
- dm_req  in  1  decoded load/store pending for current ir (valid from FETCH completion onward)
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  `W_DATA  data address
- dm_wdata  in  `W_DATA  store data
- dm_rdata  out  `W_DATA  latched load data
- stall  out  1  1 = program counter and architectural writes held
- bus_req  out  1  bus transaction request
- bus_we  out  1  bus write enable
- bus_addr  out  `W_DATA  bus address
- bus_wdata  out  `W_DATA  bus write data
- bus_rdata  in  `W_DATA  bus read data, valid with bus_ack
- bus_ack  in  1  transaction complete
- bus_err  out  1  sticky timeout/misalignment flag

Behaviour:
- States: IDLE, FETCH, DATA, COMMIT. Asynchronous reset forces IDLE.
- IDLE lasts exactly one cycle after reset deassertion, then moves to FETCH.
- Reset values: ir=NOP_WORD, dm_rdata=0, bus_err=0, timeout counter=0. In IDLE: stall=1, bus_req=0.
- FETCH:
  - Drives bus_req=1, bus_we=0, bus_addr={if_addr[31:2],2'b00}, bus_wdata=0.
  - On bus_ack: ir<=bus_rdata. Next state is DATA if dm_req is high that cycle (decode sees the new ir combinationally from the following cycle, so dm_req is sampled in the cycle after ack; see next bullet), else COMMIT.
  - Exact rule: ack in FETCH goes to an internal DECIDE sub-step of one cycle with bus_req=0. DECIDE goes to DATA if dm_req, else COMMIT.
- DATA:
  - Drives bus_req=1, bus_we=dm_we, bus_addr={dm_addr[31:2],2'b00}, bus_wdata=dm_wdata.
  - On bus_ack: if load, dm_rdata<=bus_rdata; next state is COMMIT.
  - If dm_addr[1:0]!=0 on entry: no request is issued, bus_err<=1, go directly to COMMIT.
- COMMIT: stall=0 for exactly one cycle, bus_req=0, next state FETCH.
- stall=1 in every state except COMMIT.
- Handshake rules:
  - bus_ack is honoured only when bus_req=1; an ack while bus_req=0 is ignored.
  - Ack in the first request cycle is legal (zero wait).
  - bus_req stays high, with stable address and data, until ack or timeout.
- Timeout:
  - The counter clears on entry to FETCH or DATA and increments each cycle bus_req=1 without ack.
  - On reaching TIMEOUT: bus_err<=1 (sticky until rst), bus_req drops. A fetch timeout loads ir<=NOP_WORD; a data timeout leaves dm_rdata unchanged. Then go to COMMIT.
  - Ack and timeout in the same cycle: ack wins.
- Latency with zero-wait memory: 3 cycles per non-memory instruction (FETCH, DECIDE, COMMIT) and 4 per load/store.
- Reset mid-transaction: bus_req drops immediately and asynchronously, state goes to IDLE, and the outstanding ack is ignored.

Decomposition:
- Shared constants header: state encodings (S_IDLE, S_FETCH, S_DECIDE, S_DATA, S_COMMIT), NOP_WORD. `W_DATA comes from the existing constant definitions.
- One natural sub-module: bus_timeout_ctr (clear, enable, expire output, parameterised by TIMEOUT/W_TO).
- The FSM and bus muxing stay in mem_bus_sequencer.

Test Plan:
- Zero-wait ALU instruction: ack on first FETCH cycle, bus_rdata=32'h2408_0005, dm_req=0 -> ir=32'h24080005 next cycle; stall low exactly one cycle, 3 cycles after FETCH entry; bus_req low in DECIDE/COMMIT.
- Store with waits: dm_req=1, dm_we=1, dm_addr=32'h1000_0010, dm_wdata=32'hDEAD_BEEF, ack after 3 cycles -> bus_we=1, bus_addr=32'h10000010, bus_wdata stable 3 cycles; one COMMIT cycle.
- Load: bus_rdata=32'h0000_00A5 on data ack -> dm_rdata=32'hA5 during COMMIT; stray ack while bus_req=0 in DECIDE has no effect.
- Fetch timeout (TIMEOUT=4), never ack -> bus_req high 4 cycles then low; ir=NOP_WORD; bus_err=1 and stays 1 across later good instructions.
- Misaligned load dm_addr=32'h1000_0002 -> no DATA bus_req; bus_err=1; COMMIT follows DECIDE.
- rst pulsed mid-DATA with ack pending -> bus_req=0 immediately, stall=1, ir=NOP_WORD; one IDLE cycle after deassert, then FETCH at if_addr.
